// File: rtl/pdm_audio_tx.sv
// First-order sigma-delta PDM transmitter fed from a one-entry sample buffer; one bit every CLK_DIV clocks, OSR bits per sample.
// Ready is registered (buffer empty and enabled); on a boundary with no new sample the last sample repeats and underrun pulses.
module pdm_audio_tx #(
    parameter int unsigned CLK_DIV = 100,
    parameter int unsigned OSR     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        pdm_out,
    output logic        pdm_sd,
    output logic        sample_done,
    output logic        underrun,
    output logic        busy
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(OSR);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [15:0]        buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [15:0]        cur_q, cur_d;
    logic [15:0]        acc_q, acc_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               pdm_q, pdm_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               und_q, und_d;
    logic               run_q, run_d;

    logic               wr;
    logic               bit_tick;
    logic               boundary;
    logic [16:0]        sum;

    assign wr       = sample_valid && ready_q;
    assign sum      = {1'b0, acc_q} + {1'b0, cur_q};
    assign bit_tick = (state_q == RUN) && (div_q == DIV_W'(CLK_DIV - 1));
    assign boundary = bit_tick && (bit_q == BIT_W'(OSR - 1));

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cur_d      = cur_q;
        acc_d      = acc_q;
        div_d      = div_q;
        bit_d      = bit_q;
        pdm_d      = pdm_q;
        done_d     = 1'b0;
        und_d      = 1'b0;

        if (!enable) begin
            // Disabling abandons any partial sample and restarts the modulator from zero.
            state_d    = IDLE;
            buf_full_d = 1'b0;
            acc_d      = '0;
            div_d      = '0;
            bit_d      = '0;
            pdm_d      = 1'b0;
        end else begin
            // Ready implies the buffer is empty, so a write never collides with a consume.
            if (wr) begin
                buf_d      = sample_data;
                buf_full_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (buf_full_q) begin
                        state_d    = RUN;
                        cur_d      = buf_q;
                        buf_full_d = 1'b0;
                        div_d      = '0;
                        bit_d      = '0;
                    end
                end
                RUN: begin
                    div_d = bit_tick ? '0 : div_q + DIV_W'(1);
                    if (bit_tick) begin
                        pdm_d = sum[16];
                        acc_d = sum[15:0];
                        bit_d = boundary ? '0 : bit_q + BIT_W'(1);
                    end
                    if (boundary) begin
                        done_d = 1'b1;
                        if (buf_full_q) begin
                            cur_d      = buf_q;
                            buf_full_d = 1'b0;
                        end else begin
                            und_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        run_d   = (state_d == RUN);
        ready_d = enable && !buf_full_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cur_q      <= '0;
            acc_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            pdm_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            und_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            pdm_q      <= pdm_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            und_q      <= und_d;
            run_q      <= run_d;
        end
    end

    assign sample_ready = ready_q;
    assign pdm_out      = pdm_q;
    assign pdm_sd       = run_q;
    assign busy         = run_q;
    assign sample_done  = done_q;
    assign underrun     = und_q;

endmodule

// File: doc/pdm_audio_tx.md
Name: pdm_audio_tx

Overview:
Playback-side transmitter that converts 16-bit unsigned recorded samples, read back from RAM, into a 1-bit pulse-density stream for the speaker amplifier. It is the output counterpart of the PDM microphone deserializer: a first-order sigma-delta modulator with a one-entry sample buffer, a bit-rate divider and an amplifier shutdown control. It sits between the address/RAM read path and the speak pin, and pulses a per-sample done strobe that the address counter uses to advance.

Parameters:
CLK_DIV, 100, system clocks per PDM bit (100 MHz -> 1 MHz bit rate); legal range >=2
OSR, 16, PDM bits emitted per input sample; legal range >=2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  playback enable from controller; low forces IDLE
sample_data  input  16  unsigned offset-binary sample (0x0000 = full negative, 0x8000 = mid)
sample_valid  input  1  sample_data valid
sample_ready  output  1  one-entry buffer empty; a transfer occurs when valid and ready are both high
pdm_out  output  1  PDM bit to speaker, registered
pdm_sd  output  1  amplifier enable (1 = amplifier on), registered
sample_done  output  1  one-cycle pulse when OSR bits of a sample have been emitted
underrun  output  1  one-cycle pulse when a sample boundary is reached with the buffer empty
busy  output  1  high in RUN

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, buffer empty, accumulator=0, div_cnt=0, bit_cnt=0, pdm_out=0, pdm_sd=0, sample_ready=0, sample_done=0, underrun=0, busy=0.
- sample_ready = registered (buffer empty AND enable). The buffer writes on a valid&&ready cycle. sample_ready drops on the following cycle. There is no same-cycle write and consume, because ready is low whenever the buffer is full.
- States are IDLE and RUN.
- IDLE -> RUN: enable=1 and buffer full. On that edge: cur_sample <- buffer, buffer empties, div_cnt=0, bit_cnt=0, accumulator keeps its value (0 after reset or after leaving RUN). busy and pdm_sd go high the same edge.
- RUN: div_cnt counts 0..CLK_DIV-1 and wraps. bit_tick is asserted when div_cnt==CLK_DIV-1.
- At each bit_tick: {carry, acc[15:0]} = acc[15:0] + cur_sample (17-bit sum); pdm_out <- carry; acc <- sum[15:0]; bit_cnt increments.
- The first PDM bit appears CLK_DIV cycles after entering RUN. pdm_out holds its value between ticks.
- Sample boundary is the bit_tick with bit_cnt==OSR-1. At that tick: bit_cnt <- 0 and sample_done pulses the next cycle.
  - If the buffer is full: cur_sample <- buffer and the buffer empties.
  - If the buffer is empty: cur_sample is kept (repeat last sample) and underrun pulses the same cycle as sample_done. RUN continues.
- enable=0 in any state: on the next edge go to IDLE. acc, div_cnt and bit_cnt are cleared, the buffer is flushed, and pdm_out=0, pdm_sd=0, busy=0. No sample_done is issued for a partial sample.
- Density: over N ticks with a constant sample S, the number of ones equals floor((acc0 + N*S) / 65536). S=0x0000 gives all zeros. S=0x8000 from acc=0 gives 0,1,0,1,...
- Asynchronous reset mid-sample clears everything immediately. Outputs stay at their reset values until reset deasserts.

Test Plan:
- CLK_DIV=4, OSR=4, enable=1, push 0x8000 -> RUN one cycle later. pdm_out sequence at ticks is 0,1,0,1, with ticks every 4 clocks. sample_done pulses once, 16 clocks after entry.
- Push 0x0000 then 0xFFFF back-to-back -> 4 zeros, then 0xFFFF emits 0,1,1,1 (acc from 0). Second load happens at the first boundary. sample_ready reasserts one cycle after each load.
- Push a single 0x4000 and no further samples -> boundary produces sample_done and underrun together. Pattern continues 0,0,0,1 repeating. pdm_sd stays 1.
- enable deasserted mid-sample (after 2 ticks) -> next edge: pdm_out=0, pdm_sd=0, busy=0, no sample_done. Re-enable plus push 0x8000 restarts with acc=0 (0,1,0,1).
- reset pulled low during RUN with buffer full -> all outputs 0 immediately. After release with enable=1: sample_ready=1 next cycle, no stale buffered sample is emitted.
- Default parameters, 0xC000 held for 64 ticks -> exactly 48 ones. sample_done period is 1600 clocks.
